// File: rtl/bit_4_mux_pkg.sv
// Shared types and round-robin search helper for the 4:1 mux arbiter.
package bit_4_mux_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Rotate so last+1 lands at bit 0, take the lowest set bit, rotate the index back.
    function automatic pick_t rr_next(
        input logic [N_REQ-1:0] req,
        input logic [SEL_W-1:0] last,
        input logic [N_REQ-1:0] mask
    );
        logic [N_REQ-1:0]   cand;
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [SEL_W-1:0]   enc;
        pick_t              res;

        cand = req & ~mask;
        dbl  = {cand, cand};
        rot  = N_REQ'(dbl >> ({1'b0, last} + 3'd1));
        enc  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rot[N_REQ-1-i]) enc = SEL_W'(N_REQ-1-i);
        end
        res.found = |rot;
        res.idx   = enc + last + 2'd1;
        return res;
    endfunction

endpackage

// File: rtl/bit_4_mux_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request after 'last', skipping masked ports.
module rr_pick4
    import bit_4_mux_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    pick_t pick;

    always_comb begin
        pick  = rr_next(req, last, mask);
        found = pick.found;
        idx   = pick.idx;
    end

endmodule

// File: rtl/bit_4_mux_arbiter.sv
// Round-robin owner selection and beat pacing for the shared 4:1 mux output channel.
module bit_4_mux_arbiter
    import bit_4_mux_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic [N_REQ-1:0] ack,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] sel_nxt, last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N_REQ-1:0] sel_onehot, pick_mask;
    logic [SEL_W-1:0] pick_last, pick_idx;
    logic             pick_found, transfer, at_cap, release_now;

    always_comb begin
        sel_onehot  = N_REQ'(1) << sel;
        busy        = (state == ST_GRANT);
        out_valid   = busy & req[sel];
        transfer    = out_valid & out_ready;
        ack         = transfer ? sel_onehot : '0;
        at_cap      = (cnt == CNT_W'(MAX_BURST - 1));
        release_now = busy & ((transfer & at_cap) | ~req[sel]);
        // One picker serves both IDLE arbitration and release re-arbitration.
        pick_last   = busy ? sel : last;
        pick_mask   = busy ? sel_onehot : '0;
    end

    rr_pick4 u_pick (
        .req   (req),
        .last  (pick_last),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        last_nxt  = last;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nxt = ST_GRANT;
                    sel_nxt   = pick_idx;
                    cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (transfer) cnt_nxt = cnt + 1'b1;
                if (release_now) begin
                    last_nxt = sel;
                    cnt_nxt  = '0;
                    if (pick_found) begin
                        sel_nxt = pick_idx;
                    end else if (!(transfer & at_cap)) begin
                        // A capped owner still holds req, so it alone is re-granted.
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sel   <= '0;
            cnt   <= '0;
            last  <= '1;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

endmodule

// File: tb/tb_bit_4_mux_arbiter.sv
// Bench for bit_4_mux_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_bit_4_mux_arbiter;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       out_ready = 1'b0;
    logic [1:0] sel;
    logic       out_valid;
    logic [3:0] ack;
    logic       busy;

    int total = 0;
    int bad = 0;

    bit_4_mux_arbiter #(.MAX_BURST(MAXB), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the channel, how many beats it has had, who went last.
    int         m_owner, m_last, m_beats;
    bit         m_granted;
    bit         m_fed, m_capped;
    int         m_nxt;
    logic       exp_valid;
    logic [3:0] exp_ack;
    logic [3:0] ack_seen;
    int         wait_beats[4];
    int         max_wait = 0;

    function automatic int rr_search(input logic [3:0] r, input int from, input int skip);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (from + k) % 4;
            if (r[i] && i != skip) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_owner = 0; m_last = 3; m_beats = 0; m_granted = 0;
            for (int i = 0; i < 4; i++) wait_beats[i] = 0;
        end

        exp_valid = m_granted && req[m_owner];
        exp_ack   = (exp_valid && out_ready) ? (4'b0001 << m_owner) : 4'b0000;
        check("model_sel", sel, m_owner);
        check("model_busy", busy, m_granted);
        check("model_out_valid", out_valid, exp_valid);
        check("model_ack", ack, exp_ack);
        check("ack_onehot0", $onehot0(ack), 1);
        check("ack_implies_valid", (ack != 4'b0000) && !out_valid, 0);
        ack_seen = ack;

        // Beats granted to others while a requester sits waiting.
        for (int i = 0; i < 4; i++) begin
            if (!rst_n || !req[i] || ack[i]) wait_beats[i] = 0;
            else if (ack != 4'b0000) begin
                wait_beats[i]++;
                if (wait_beats[i] > max_wait) max_wait = wait_beats[i];
            end
        end

        if (rst_n) begin
            if (!m_granted) begin
                if (req != 4'b0000) begin
                    m_owner   = rr_search(req, m_last, -1);
                    m_granted = 1;
                    m_beats   = 0;
                end
            end else begin
                m_fed = req[m_owner] && out_ready;
                if (m_fed) m_beats++;
                m_capped = m_fed && (m_beats == MAXB);
                if (m_capped || !req[m_owner]) begin
                    m_last = m_owner;
                    m_nxt  = rr_search(req, m_last, m_owner);
                    if (m_nxt >= 0) begin
                        m_owner = m_nxt;
                        m_beats = 0;
                    end else if (m_capped) m_beats = 0;
                    else m_granted = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ack", ack, 0);

        // Single requester: continuous acks through the cap re-grant.
        do_reset();
        req = 4'b0001; out_ready = 1'b1;
        @(negedge clk);
        check("t2_latency_busy", busy, 0);
        check("t2_latency_ack", ack, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            check("t2_ack", ack, 4'b0001);
            check("t2_busy", busy, 1);
        end
        step();
        req = 4'b0000; out_ready = 1'b0;

        // All requesting: 4 beats each in order 0,1,2,3,0, no gaps.
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        step();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t3_sel", sel, (k / 4) % 4);
            check("t3_ack", ack, 1 << ((k / 4) % 4));
            step();
        end
        // Mid-burst async reset: outputs clear without waiting for a clock.
        #1 rst_n = 1'b0;
        #1;
        check("t1_sel", sel, 0);
        check("t1_valid", out_valid, 0);
        check("t1_ack", ack, 0);
        check("t1_busy", busy, 0);
        step();
        req = 4'b0000; out_ready = 1'b0;
        rst_n = 1'b1;

        // Backpressure on owner 2, then hand-over to 3 after four accepted beats.
        do_reset();
        req = 4'b0100; out_ready = 1'b0;
        step();
        req = 4'b1100;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_stall_sel", sel, 2);
            check("t4_stall_valid", out_valid, 1);
            check("t4_stall_ack", ack, 0);
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4_ack", ack, 4'b0100);
            step();
        end
        @(negedge clk);
        check("t4_handover_sel", sel, 3);
        check("t4_handover_ack", ack, 4'b1000);
        step();
        req = 4'b0000; out_ready = 1'b0;

        // Early drop by owner 1 after two beats.
        do_reset();
        req = 4'b0010; out_ready = 1'b1;
        step();
        req = 4'b1010;
        @(negedge clk);
        check("t5_beat1", ack, 4'b0010);
        step();
        @(negedge clk);
        check("t5_beat2", ack, 4'b0010);
        step();
        req = 4'b1000;
        @(negedge clk);
        check("t5_drop_ack", ack, 0);
        check("t5_drop_valid", out_valid, 0);
        check("t5_drop_sel", sel, 1);
        step();
        @(negedge clk);
        check("t5_next_sel", sel, 3);
        check("t5_next_ack", ack, 4'b1000);
        step();
        req = 4'b0000; out_ready = 1'b0;

        // Pointer wrap: after reset port 0 beats port 3.
        do_reset();
        req = 4'b1001; out_ready = 1'b1;
        step();
        @(negedge clk);
        check("t6_first_sel", sel, 0);
        repeat (4) step();
        @(negedge clk);
        check("t6_second_sel", sel, 3);
        check("t6_second_ack", ack, 4'b1000);
        step();
        req = 4'b0000; out_ready = 1'b0;

        // Random traffic: requests held until acked, occasional early drops.
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (req[i] && ack_seen[i]) req[i] = ($urandom_range(0, 99) < 60);
                else if (req[i]) begin
                    if ($urandom_range(0, 99) < 2) req[i] = 1'b0;
                end else req[i] = ($urandom_range(0, 99) < 25);
            end
            out_ready = ($urandom_range(0, 99) < 70);
        end
        step();
        check("max_wait_le_cap", max_wait <= 3 * MAXB, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
